// File: rtl/sbox_pipe.sv
// Two-stage AES byte substitution pipeline: per-beat forward or inverse S-box on LANES bytes,
// valid/ready on both sides, sideband tag carried through, flush and handshake counter.
module sbox_pipe #(
    parameter int unsigned LANES = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_inv,
    input  logic [8*LANES-1:0]   in_data,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic [TAG_W-1:0]     out_tag,
    output logic [15:0]          beat_count
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ x;
            end
            x = xtime(x);
        end
        return acc;
    endfunction

    // a^254 == a^-1 in GF(2^8); also maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] affine_fwd(input logic [7:0] a);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [7:0] affine_inv(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x, input logic inv);
        logic [7:0] r;
        if (inv) begin
            r = gf_inv(affine_inv(x));
        end else begin
            r = affine_fwd(gf_inv(x));
        end
        return r;
    endfunction

    logic                 s1_valid;
    logic                 s1_inv;
    logic [8*LANES-1:0]   s1_data;
    logic [TAG_W-1:0]     s1_tag;
    logic                 s2_valid;
    logic [8*LANES-1:0]   s2_data;
    logic [TAG_W-1:0]     s2_tag;
    logic [15:0]          count;

    logic                 s2_adv;
    logic                 s1_adv;
    logic                 in_fire;
    logic                 out_fire;
    logic                 s2_load;
    logic [8*LANES-1:0]   sub_data;

    always_comb begin
        s2_adv   = !s2_valid || out_ready;
        s1_adv   = !s1_valid || s2_adv;
        in_ready = s1_adv && !flush && !rst;
        in_fire  = in_valid && in_ready;
        out_fire = s2_valid && out_ready;
        s2_load  = s2_adv && s1_valid && !flush;
    end

    always_comb begin
        sub_data = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            sub_data[8*k +: 8] = sbox(s1_data[8*k +: 8], s1_inv);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_inv   <= 1'b0;
            s1_data  <= '0;
            s1_tag   <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_tag   <= '0;
            count    <= 16'h0000;
        end else begin
            // A handshake coinciding with flush still completes and counts
            if (out_fire) begin
                count <= count + 16'h0001;
            end
            if (flush) begin
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
            end else begin
                if (s2_adv) begin
                    s2_valid <= s1_valid;
                end
                if (s1_adv) begin
                    s1_valid <= in_fire;
                end
            end
            if (s2_load) begin
                s2_data <= sub_data;
                s2_tag  <= s1_tag;
            end
            if (in_fire) begin
                s1_data <= in_data;
                s1_inv  <= in_inv;
                s1_tag  <= in_tag;
            end
        end
    end

    // Empty output stage presents zeros rather than stale data
    assign out_valid  = s2_valid;
    assign out_data   = s2_valid ? s2_data : '0;
    assign out_tag    = s2_valid ? s2_tag : '0;
    assign beat_count = count;

endmodule

// File: tb/tb_sbox_pipe.sv
// Bench for sbox_pipe: directed scenarios plus random traffic, all checked by one negedge
// process against a queue model whose S-box tables are derived from GF(2^8) arithmetic.
module tb_sbox_pipe;

    localparam int unsigned LANES = 4;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned DW    = 8 * LANES;
    localparam int NPIN = 6;
    localparam int P_DATA = 0, P_TAG = 1, P_OV = 2, P_IR = 3, P_CNT = 4, P_FWD = 5, P_INV = 6,
                   P_VAL = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic             in_inv;
    logic [DW-1:0]    in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [TAG_W-1:0] out_tag;
    logic [15:0]      beat_count;

    always #5 clk = ~clk;

    sbox_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inv     (in_inv),
        .in_data    (in_data),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .beat_count (beat_count)
    );

    typedef struct {
        logic [DW-1:0]    d;
        logic [TAG_W-1:0] tag;
        int               acc;
    } beat_t;

    logic [7:0]   fwd_tab [256];
    logic [7:0]   inv_tab [256];
    beat_t        q[$];
    int           n_total = 0;
    int           n_pass  = 0;
    int           cyc     = 0;
    logic [15:0]  m_cnt   = 16'h0000;
    bit           mon_en  = 1'b0;

    bit           pin_v   [NPIN];
    int           pin_sel [NPIN];
    logic [127:0] pin_exp [NPIN];
    logic [127:0] pin_act [NPIN];
    string        pin_nm  [NPIN];
    int           pin_n = 0;

    bit           last_acc;
    bit           last_out;

    function automatic logic [7:0] gf_mul_ref(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ ({8'h00, a} << i);
        end
        for (int i = 14; i >= 8; i--) begin
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        end
        return p[7:0];
    endfunction

    function automatic logic [7:0] affine_ref(input logic [7:0] y);
        logic [7:0] c;
        logic [7:0] s;
        c = 8'h63;
        for (int i = 0; i < 8; i++) begin
            s[i] = y[i] ^ y[(i+4)%8] ^ y[(i+5)%8] ^ y[(i+6)%8] ^ y[(i+7)%8] ^ c[i];
        end
        return s;
    endfunction

    function automatic logic [DW-1:0] model_sub(input logic [DW-1:0] d, input logic inv);
        logic [DW-1:0] r;
        for (int k = 0; k < int'(LANES); k++) begin
            r[8*k +: 8] = inv ? inv_tab[d[8*k +: 8]] : fwd_tab[d[8*k +: 8]];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic pin(input string nm, input int sel, input logic [127:0] exp,
                       input logic [127:0] act);
        if (pin_n < NPIN) begin
            pin_nm[pin_n]  = nm;
            pin_sel[pin_n] = sel;
            pin_exp[pin_n] = exp;
            pin_act[pin_n] = act;
            pin_v[pin_n]   = 1'b1;
            pin_n++;
        end
    endtask

    // Inputs change just after posedge; the compare process samples at negedge.
    task automatic step();
        @(negedge clk);
        last_acc = in_valid && in_ready;
        last_out = out_valid && out_ready;
        #1;
        for (int i = 0; i < NPIN; i++) pin_v[i] = 1'b0;
        pin_n = 0;
        @(posedge clk);
        #1;
    endtask

    logic [127:0] mon_a;
    bit           mon_fire;
    bit           mon_expv;
    bit           mon_expr;
    int           mon_occ;

    always @(negedge clk) begin
        for (int i = 0; i < NPIN; i++) begin
            if (pin_v[i]) begin
                case (pin_sel[i])
                    P_DATA:  mon_a = 128'(out_data);
                    P_TAG:   mon_a = 128'(out_tag);
                    P_OV:    mon_a = 128'(out_valid);
                    P_IR:    mon_a = 128'(in_ready);
                    P_CNT:   mon_a = 128'(beat_count);
                    P_FWD:   mon_a = 128'(fwd_tab[pin_act[i][7:0]]);
                    P_INV:   mon_a = 128'(inv_tab[pin_act[i][7:0]]);
                    default: mon_a = pin_act[i];
                endcase
                chk(pin_nm[i], mon_a, pin_exp[i]);
            end
        end
        if (mon_en) begin
            cyc++;
            mon_fire = out_valid && out_ready;
            mon_expv = 1'b0;
            if (q.size() > 0) begin
                if (cyc - q[0].acc >= 2) mon_expv = 1'b1;
            end
            chk("out_valid", 128'(out_valid), 128'(mon_expv));
            if (out_valid && q.size() > 0) begin
                chk("out_data", 128'(out_data), 128'(q[0].d));
                chk("out_tag", 128'(out_tag), 128'(q[0].tag));
            end
            if (!out_valid) begin
                chk("idle_data", 128'(out_data), 128'(0));
                chk("idle_tag", 128'(out_tag), 128'(0));
            end
            chk("beat_count", 128'(beat_count), 128'(m_cnt));
            mon_occ  = q.size() - (mon_fire ? 1 : 0);
            mon_expr = !rst && !flush && (mon_occ < 2);
            chk("in_ready", 128'(in_ready), 128'(mon_expr));
            if (rst) begin
                q.delete();
                m_cnt = 16'h0000;
            end else begin
                if (mon_fire) begin
                    m_cnt++;
                    if (q.size() > 0) void'(q.pop_front());
                end
                if (flush) q.delete();
                if (in_valid && in_ready) begin
                    q.push_back('{d: model_sub(in_data, in_inv), tag: in_tag, acc: cyc});
                end
            end
        end
    end

    initial begin
        int unsigned   sent;
        int unsigned   delivered;
        logic [7:0]    y;
        logic [DW-1:0] d;
        logic [DW-1:0] f;
        logic [DW-1:0] dt [4];
        logic          it [4];

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inv = 1'b0;
        in_data = '0; in_tag = '0; out_ready = 1'b0;

        for (int x = 0; x < 256; x++) begin
            y = 8'h00;
            for (int c = 1; c < 256; c++) begin
                if (gf_mul_ref(8'(x), 8'(c)) == 8'h01) y = 8'(c);
            end
            fwd_tab[x] = affine_ref(y);
        end
        for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);

        step();
        pin("rst_out_valid", P_OV, 0, 0);
        pin("rst_out_data", P_DATA, 0, 0);
        pin("rst_out_tag", P_TAG, 0, 0);
        pin("rst_count", P_CNT, 0, 0);
        pin("rst_in_ready", P_IR, 0, 0);
        pin("tab_fwd_53", P_FWD, 128'h0ed, 128'h53);
        step();
        rst = 1'b0;
        mon_en = 1'b1;
        pin("ready_after_rst", P_IR, 1, 0);
        pin("tab_fwd_00", P_FWD, 128'h063, 128'h00);
        pin("tab_inv_00", P_INV, 128'h052, 128'h00);
        pin("tab_inv_ff", P_INV, 128'h07d, 128'hff);
        step();

        // Eight beats with a three-cycle output stall
        sent = 0;
        for (int c = 0; c < 30; c++) begin
            in_valid  = (sent < 8);
            in_inv    = 1'($urandom & 1);
            in_data   = DW'($urandom);
            in_tag    = TAG_W'(sent);
            out_ready = !(c >= 3 && c <= 5);
            step();
            if (last_acc) sent++;
        end
        in_valid = 1'b0;
        pin("stall_sent", P_VAL, 8, 128'(sent));
        pin("stall_count", P_CNT, 8, 0);
        step();

        // Back-to-back mode alternation with literal vectors
        dt[0] = 32'hff53_0100; it[0] = 1'b0;
        dt[1] = 32'hff63_0100; it[1] = 1'b1;
        dt[2] = DW'($urandom); it[2] = 1'b0;
        dt[3] = DW'($urandom); it[3] = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_valid = (c < 4);
            if (c < 4) begin
                in_data = dt[c];
                in_inv  = it[c];
                in_tag  = TAG_W'(c);
            end
            if (c == 2) pin("vec_fwd", P_DATA, 128'h16ed_7c63, 0);
            if (c == 3) pin("vec_inv", P_DATA, 128'h7d00_0952, 0);
            step();
        end

        // Forward-then-inverse round trip over every byte value
        for (int b = 0; b < 256; b += int'(LANES)) begin
            for (int k = 0; k < int'(LANES); k++) d[8*k +: 8] = 8'(b + k);
            in_valid = 1'b1; in_inv = 1'b0; in_data = d; in_tag = TAG_W'(b);
            step();
            in_valid = 1'b0;
            step();
            f = out_data;
            in_valid = 1'b1; in_inv = 1'b1; in_data = f;
            step();
            in_valid = 1'b0;
            step();
            pin("roundtrip", P_DATA, 128'(d), 0);
            pin("roundtrip_valid", P_OV, 1, 0);
            step();
        end

        // Flush with both stages full
        out_ready = 1'b0;
        in_valid = 1'b1; in_inv = 1'b0; in_data = DW'($urandom); in_tag = 4'h1;
        step();
        in_data = DW'($urandom); in_tag = 4'h2;
        step();
        in_data = DW'($urandom); in_tag = 4'h3;
        flush = 1'b1;
        pin("full_out_valid", P_OV, 1, 0);
        pin("flush_in_ready", P_IR, 0, 0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        pin("flush_out_valid", P_OV, 0, 0);
        pin("flush_count", P_CNT, 128'(8 + 4 + 2 * (256 / LANES)), 0);
        step();
        in_valid = 1'b1; in_inv = 1'b0; in_data = 32'hff53_0100; in_tag = 4'h9;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        pin("post_flush_lat1", P_OV, 0, 0);
        step();
        pin("post_flush_lat2", P_OV, 1, 0);
        pin("post_flush_data", P_DATA, 128'h16ed_7c63, 0);
        pin("post_flush_tag", P_TAG, 128'h9, 0);
        step();

        // Counter wrap after 65536 handshakes
        rst = 1'b1;
        step();
        rst = 1'b0;
        sent = 0;
        delivered = 0;
        for (int c = 0; c < 70000 && delivered < 65536; c++) begin
            if (delivered == 65535) pin("count_ffff", P_CNT, 128'hffff, 0);
            in_valid  = (sent < 65536);
            in_inv    = 1'($urandom & 1);
            in_data   = DW'($urandom);
            in_tag    = TAG_W'($urandom);
            out_ready = 1'b1;
            step();
            if (last_acc) sent++;
            if (last_out) delivered++;
        end
        in_valid = 1'b0;
        pin("wrap_delivered", P_VAL, 65536, 128'(delivered));
        pin("count_wrap", P_CNT, 0, 0);
        step();

        // Reset with both stages full
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = DW'($urandom); in_tag = 4'h5;
        step();
        in_data = DW'($urandom); in_tag = 4'h6;
        step();
        rst = 1'b1; out_ready = 1'b1;
        pin("rst_hold_in_ready", P_IR, 0, 0);
        pin("rst_full_valid", P_OV, 1, 0);
        step();
        rst = 1'b0; in_valid = 1'b0;
        pin("mid_rst_valid", P_OV, 0, 0);
        pin("mid_rst_data", P_DATA, 0, 0);
        pin("mid_rst_tag", P_TAG, 0, 0);
        pin("mid_rst_count", P_CNT, 0, 0);
        pin("mid_rst_ready", P_IR, 1, 0);
        step();

        // Random traffic with occasional flush and reset
        for (int c = 0; c < 2000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_inv    = 1'($urandom & 1);
            in_data   = DW'($urandom);
            in_tag    = TAG_W'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
